// File: rtl/pio_read_pkg.sv
// Shared types and default constants for the PIO-driven serial read sequencer.
package pio_read_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_CLK_DIV = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // States in which the serial bus is owned and the divider runs.
    function automatic logic is_busy(input state_e s);
        return (s == ST_SETUP) || (s == ST_SHIFT) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/pio_read_sequencer_sclk_phase_gen.sv
// Clock-divider phase counter: pulses phase_end_o on the last cycle of every
// CLK_DIV-cycle phase while enabled; held cleared while disabled.
module sclk_phase_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en_i,
    output logic phase_end_o
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign phase_end_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/pio_read_sequencer.sv
// Serial read sequencer started by a PIO request level; shifts DATA_W bits MSB
// first from a device and presents the word with a 4-phase done handshake.
module pio_read_sequencer
    import pio_read_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              read_req,
    input  logic              sdi,
    output logic              sclk,
    output logic              cs_n,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    output logic              busy
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_e              state_q, state_d;
    logic                sdi_meta_q, sdi_sync_q;
    logic                read_req_q;
    logic                sclk_q, sclk_d;
    logic                cs_n_q, cs_n_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                phase_end;
    logic                start;

    sclk_phase_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .en_i        (is_busy(state_q)),
        .phase_end_o (phase_end)
    );

    assign start = read_req && !read_req_q;

    always_comb begin
        state_d   = state_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        done_d    = done_q;
        data_d    = data_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SETUP;
                    cs_n_d    = 1'b0;
                    bit_cnt_d = '0;
                end
            end
            ST_SETUP: begin
                if (phase_end) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (phase_end) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // End of high phase: sample, drop sclk, advance bit.
                        sclk_d    = 1'b0;
                        shift_d   = {shift_q[DATA_W-2:0], sdi_sync_q};
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (phase_end) begin
                    state_d   = ST_DONE;
                    cs_n_d    = 1'b1;
                    done_d    = 1'b1;
                    data_d    = shift_q;
                    bit_cnt_d = '0;
                end
            end
            ST_DONE: begin
                if (!read_req) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sclk_d  = 1'b0;
                cs_n_d  = 1'b1;
                done_d  = 1'b0;
            end
        endcase
        busy_d = is_busy(state_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sdi_meta_q <= 1'b0;
            sdi_sync_q <= 1'b0;
            read_req_q <= 1'b0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            data_q     <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            sdi_meta_q <= sdi;
            sdi_sync_q <= sdi_meta_q;
            read_req_q <= read_req;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            data_q     <= data_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign sclk     = sclk_q;
    assign cs_n     = cs_n_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign data_out = data_q;

endmodule

// File: tb/tb_pio_read_sequencer.sv
// Directed bench: two sequencer instances (16-bit/div4 and 8-bit/div3) each
// driven by a simple SPI-style device that shifts on sclk falling edges.
module tb_pio_read_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        read_req16 = 1'b0, sdi16 = 1'b0, sclk16, cs_n16, done16, busy16;
    logic [15:0] data16;
    logic        read_req8 = 1'b0, sdi8 = 1'b0, sclk8, cs_n8, done8, busy8;
    logic [7:0]  data8;

    logic [15:0] dev_word16 = 16'h0000, dev_sh16 = 16'h0000;
    logic [7:0]  dev_word8 = 8'h00, dev_sh8 = 8'h00;
    int          edges16 = 0, edges8 = 0;
    int          n_checks = 0, n_fails = 0;

    always #5 clk = ~clk;

    pio_read_sequencer u_dut16 (
        .clk      (clk),
        .reset_n  (reset_n),
        .read_req (read_req16),
        .sdi      (sdi16),
        .sclk     (sclk16),
        .cs_n     (cs_n16),
        .data_out (data16),
        .done     (done16),
        .busy     (busy16)
    );

    pio_read_sequencer #(
        .DATA_W  (8),
        .CLK_DIV (3)
    ) u_dut8 (
        .clk      (clk),
        .reset_n  (reset_n),
        .read_req (read_req8),
        .sdi      (sdi8),
        .sclk     (sclk8),
        .cs_n     (cs_n8),
        .data_out (data8),
        .done     (done8),
        .busy     (busy8)
    );

    // Device models: present MSB on select, shift on each sclk falling edge.
    always @(negedge cs_n16) begin
        dev_sh16 = dev_word16;
        sdi16    = dev_sh16[15];
    end
    always @(negedge sclk16) begin
        if (!cs_n16) begin
            dev_sh16 = {dev_sh16[14:0], 1'b0};
            sdi16    = dev_sh16[15];
        end
    end
    always @(negedge cs_n8) begin
        dev_sh8 = dev_word8;
        sdi8    = dev_sh8[7];
    end
    always @(negedge sclk8) begin
        if (!cs_n8) begin
            dev_sh8 = {dev_sh8[6:0], 1'b0};
            sdi8    = dev_sh8[7];
        end
    end

    always @(posedge sclk16) edges16++;
    always @(posedge sclk8)  edges8++;

    // Counts rising clk edges until done is seen high; -1 if the bound expires.
    task automatic wait_done(input bit sel8, input int start_cnt, output int cyc);
        logic d;
        cyc = start_cnt;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            d = sel8 ? done8 : done16;
            if (d === 1'b1) return;
        end
        cyc = -1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        read_req16 = 1'b0;
        read_req8  = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (cs_n16 !== 1'b1) begin n_fails++; $display("FAIL reset_cs_n16: got %b expected 1", cs_n16); end
        n_checks++; if (sclk16 !== 1'b0) begin n_fails++; $display("FAIL reset_sclk16: got %b expected 0", sclk16); end
        n_checks++; if (done16 !== 1'b0) begin n_fails++; $display("FAIL reset_done16: got %b expected 0", done16); end
        n_checks++; if (busy16 !== 1'b0) begin n_fails++; $display("FAIL reset_busy16: got %b expected 0", busy16); end
        n_checks++; if (data16 !== 16'h0000) begin n_fails++; $display("FAIL reset_data16: got %h expected 0000", data16); end
        n_checks++; if (cs_n8 !== 1'b1) begin n_fails++; $display("FAIL reset_cs_n8: got %b expected 1", cs_n8); end
        n_checks++; if (data8 !== 8'h00) begin n_fails++; $display("FAIL reset_data8: got %h expected 00", data8); end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (busy16 !== 1'b0 || cs_n16 !== 1'b1) begin n_fails++; $display("FAIL idle_after_reset: busy=%b cs_n=%b expected 0/1", busy16, cs_n16); end
        $display("reset: cs_n16=%b sclk16=%b data16=%h data8=%h", cs_n16, sclk16, data16, data8);
    endtask

    task automatic test_basic_read();
        int cyc;
        dev_word16 = 16'hA55A;
        edges16 = 0;
        read_req16 = 1'b1;
        #1;
        n_checks++; if (cs_n16 !== 1'b1) begin n_fails++; $display("FAIL basic_cs_before_edge: got %b expected 1", cs_n16); end
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (cs_n16 !== 1'b0 || busy16 !== 1'b1) begin n_fails++; $display("FAIL basic_select: cs_n=%b busy=%b expected 0/1", cs_n16, busy16); end
        wait_done(1'b0, 1, cyc);
        n_checks++; if (cyc !== 137) begin n_fails++; $display("FAIL basic_latency: got %0d cycles expected 137", cyc); end
        n_checks++; if (edges16 !== 16) begin n_fails++; $display("FAIL basic_sclk_edges: got %0d expected 16", edges16); end
        n_checks++; if (data16 !== 16'hA55A) begin n_fails++; $display("FAIL basic_data: got %h expected a55a", data16); end
        n_checks++; if (busy16 !== 1'b0 || cs_n16 !== 1'b1 || sclk16 !== 1'b0) begin n_fails++; $display("FAIL basic_done_bus: busy=%b cs_n=%b sclk=%b expected 0/1/0", busy16, cs_n16, sclk16); end
        $display("read16: data=%h cycles=%0d sclk_edges=%0d", data16, cyc, edges16);
    endtask

    task automatic test_hold_request();
        int bad;
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (done16 !== 1'b1 || busy16 !== 1'b0 || data16 !== 16'hA55A) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fails++; $display("FAIL hold_done_stable: got %0d bad cycles expected 0", bad); end
        read_req16 = 1'b0;
        #1;
        n_checks++; if (done16 !== 1'b1) begin n_fails++; $display("FAIL hold_done_before_edge: got %b expected 1", done16); end
        @(negedge clk);
        n_checks++; if (done16 !== 1'b0 || busy16 !== 1'b0) begin n_fails++; $display("FAIL hold_done_clear: done=%b busy=%b expected 0/0", done16, busy16); end
        $display("hold: read_req held 500 cycles, done cleared after release, done=%b", done16);
    endtask

    task automatic test_mid_toggle();
        int cyc;
        dev_word16 = 16'h3C96;
        edges16 = 0;
        read_req16 = 1'b1;
        repeat (20) @(negedge clk);
        read_req16 = 1'b0;
        repeat (20) @(negedge clk);
        read_req16 = 1'b1;
        @(negedge clk);
        read_req16 = 1'b0;
        wait_done(1'b0, 41, cyc);
        n_checks++; if (cyc !== 137) begin n_fails++; $display("FAIL toggle_latency: got %0d cycles expected 137", cyc); end
        n_checks++; if (data16 !== 16'h3C96) begin n_fails++; $display("FAIL toggle_data: got %h expected 3c96", data16); end
        @(negedge clk);
        n_checks++; if (done16 !== 1'b0) begin n_fails++; $display("FAIL toggle_done_one_cycle: got %b expected 0", done16); end
        repeat (200) @(negedge clk);
        n_checks++; if (edges16 !== 16 || cs_n16 !== 1'b1 || busy16 !== 1'b0) begin n_fails++; $display("FAIL toggle_no_restart: edges=%0d cs_n=%b busy=%b expected 16/1/0", edges16, cs_n16, busy16); end
        $display("toggle16: data=%h cycles=%0d sclk_edges=%0d", data16, cyc, edges16);
    endtask

    task automatic test_reset_abort();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (data16 !== 16'h0000) begin n_fails++; $display("FAIL abort_prior_data: got %h expected 0000", data16); end
        dev_word16 = 16'h5A5A;
        read_req16 = 1'b1;
        repeat (60) @(negedge clk);
        reset_n = 1'b0;
        read_req16 = 1'b0;
        #1;
        n_checks++; if (cs_n16 !== 1'b1 || sclk16 !== 1'b0) begin n_fails++; $display("FAIL abort_bus: cs_n=%b sclk=%b expected 1/0", cs_n16, sclk16); end
        n_checks++; if (done16 !== 1'b0 || busy16 !== 1'b0) begin n_fails++; $display("FAIL abort_flags: done=%b busy=%b expected 0/0", done16, busy16); end
        n_checks++; if (data16 !== 16'h0000) begin n_fails++; $display("FAIL abort_data: got %h expected 0000", data16); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (300) @(negedge clk);
        n_checks++; if (done16 !== 1'b0 || cs_n16 !== 1'b1 || data16 !== 16'h0000) begin n_fails++; $display("FAIL abort_no_restart: done=%b cs_n=%b data=%h expected 0/1/0000", done16, cs_n16, data16); end
        $display("abort16: reset at cycle 60, data=%h done=%b", data16, done16);
    endtask

    task automatic test_small_word();
        int cyc;
        dev_word8 = 8'h81;
        edges8 = 0;
        read_req8 = 1'b1;
        wait_done(1'b1, 0, cyc);
        n_checks++; if (cyc !== 55) begin n_fails++; $display("FAIL small_latency: got %0d cycles expected 55", cyc); end
        n_checks++; if (edges8 !== 8) begin n_fails++; $display("FAIL small_sclk_edges: got %0d expected 8", edges8); end
        n_checks++; if (data8 !== 8'h81) begin n_fails++; $display("FAIL small_data: got %h expected 81", data8); end
        read_req8 = 1'b0;
        @(negedge clk);
        n_checks++; if (done8 !== 1'b0) begin n_fails++; $display("FAIL small_done_clear: got %b expected 0", done8); end
        $display("read8: data=%h cycles=%0d sclk_edges=%0d", data8, cyc, edges8);
    endtask

    task automatic test_back_to_back();
        int cyc;
        dev_word16 = 16'h1234;
        edges16 = 0;
        read_req16 = 1'b1;
        wait_done(1'b0, 0, cyc);
        n_checks++; if (cyc !== 137) begin n_fails++; $display("FAIL b2b_first_latency: got %0d cycles expected 137", cyc); end
        n_checks++; if (data16 !== 16'h1234) begin n_fails++; $display("FAIL b2b_first_data: got %h expected 1234", data16); end
        $display("b2b first: data=%h cycles=%0d", data16, cyc);
        dev_word16 = 16'hFFFF;
        read_req16 = 1'b0;
        @(negedge clk);
        read_req16 = 1'b1;
        wait_done(1'b0, 0, cyc);
        n_checks++; if (cyc !== 137) begin n_fails++; $display("FAIL b2b_second_latency: got %0d cycles expected 137", cyc); end
        n_checks++; if (data16 !== 16'hFFFF) begin n_fails++; $display("FAIL b2b_second_data: got %h expected ffff", data16); end
        n_checks++; if (edges16 !== 32) begin n_fails++; $display("FAIL b2b_sclk_edges: got %0d expected 32", edges16); end
        $display("b2b second: data=%h cycles=%0d sclk_edges=%0d", data16, cyc, edges16);
        read_req16 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_hold_request();
        test_mid_toggle();
        test_reset_abort();
        test_small_word();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
